fsm_receive_data: RTL

FSM_RECEIVE_DATA -- requirements
Module: fsm_receive_data

---
 rtl/fsm_receive_data_if.sv | 19 +
 rtl/fsm_receive_data.sv | 71 +++++++
 2 files changed

// File: rtl/fsm_receive_data_if.sv
// fsm_receive_data_if: byte-in / word-out bus between a UART receiver side and the frame assembler
interface fsm_receive_data_if;
  logic        i_en_recv;
  logic        i_rx_ready;
  logic [7:0]  i_rx_data;
  logic [15:0] o_data_out;
  logic        o_data_valid;
  logic        o_timeout_err;
  logic [7:0]  o_frame_count;
  logic        o_busy;
  modport master (
    output i_en_recv, i_rx_ready, i_rx_data,
    input  o_data_out, o_data_valid, o_timeout_err, o_frame_count, o_busy
  );
  modport slave (
    input  i_en_recv, i_rx_ready, i_rx_data,
    output o_data_out, o_data_valid, o_timeout_err, o_frame_count, o_busy
  );
endinterface

// File: rtl/fsm_receive_data.sv
// fsm_receive_data: assembles two UART bytes (low then high) into a 16-bit word with an inter-byte timeout
module fsm_receive_data #(
  parameter int TIMEOUT = 50000
) (
  input logic clk,
  input logic reset,
  fsm_receive_data_if.slave bus
);
  typedef enum logic [1:0] {IDLE = 2'd0, WAIT_LO = 2'd1, WAIT_HI = 2'd2} state_t;
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);
  state_t      r_state;
  state_t      w_next;
  logic [15:0] r_timer;
  logic [7:0]  r_lo;
  logic [15:0] r_data_out;
  logic        r_data_valid;
  logic        r_timeout_err;
  logic [7:0]  r_frame_count;
  logic        r_busy;
  logic        w_take_lo;
  logic        w_done;
  logic        w_tmo;
  logic        w_after;
  assign w_after = bus.i_en_recv;
  always_comb begin
    w_next    = IDLE;
    w_take_lo = 1'b0;
    w_done    = 1'b0;
    w_tmo     = 1'b0;
    case (r_state)
      IDLE: w_next = w_after ? WAIT_LO : IDLE;
      WAIT_LO: begin
        w_take_lo = bus.i_rx_ready;
        w_next    = bus.i_rx_ready ? WAIT_HI : (w_after ? WAIT_LO : IDLE);
      end
      WAIT_HI: begin
        // a byte arriving in the last allowed cycle wins over the timeout
        w_done = bus.i_rx_ready;
        w_tmo  = !bus.i_rx_ready && (r_timer == TMO_LAST);
        w_next = (w_done || w_tmo) ? (w_after ? WAIT_LO : IDLE) : WAIT_HI;
      end
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= IDLE;
      r_timer       <= '0;
      r_lo          <= '0;
      r_data_out    <= '0;
      r_data_valid  <= 1'b0;
      r_timeout_err <= 1'b0;
      r_frame_count <= '0;
      r_busy        <= 1'b0;
    end else begin
      r_state       <= w_next;
      r_timer       <= (w_next != r_state) ? 16'd0 : ((r_timer == 16'hFFFF) ? r_timer : r_timer + 16'd1);
      r_lo          <= w_take_lo ? bus.i_rx_data : (w_tmo ? 8'h00 : r_lo);
      r_data_out    <= w_done ? {bus.i_rx_data, r_lo} : r_data_out;
      r_data_valid  <= w_done;
      r_timeout_err <= w_tmo;
      r_frame_count <= w_done ? r_frame_count + 8'd1 : r_frame_count;
      r_busy        <= (w_next != IDLE);
    end
  end
  assign bus.o_data_out    = r_data_out;
  assign bus.o_data_valid  = r_data_valid;
  assign bus.o_timeout_err = r_timeout_err;
  assign bus.o_frame_count = r_frame_count;
  assign bus.o_busy        = r_busy;
endmodule
